median_result_writer: RTL and testbench
=======================================

Name: median_result_writer

Overview:
- Sink for the median result stream (writeEnable, xMedianAddress, yMedianAddress, dataOut) produced by the median filtering path.
- Checks that result pixels arrive in raster order and packs the 1-bit pixels LSB-first into bytes.
- Writes each byte to the byte-wide output frame RAM through a simple write port.
- Flags frame completion so the readout side can start fetching the filtered image.

Parameters:
- OUT_WIDTH, 238, filtered image width in pixels (IMAGE_WIDTH - WINDOW_SIZE + 1)
- OUT_HEIGHT, 178, filtered image height in pixels
- ADDR_WIDTH, 13, output RAM byte address width; must cover ceil(OUT_WIDTH*OUT_HEIGHT/8) bytes

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- frameStart  in  1  one-cycle pulse; arms or re-arms capture of a new frame
- writeEnable  in  1  median result valid this cycle
- xMedianAddress  in  8  result column, 0..OUT_WIDTH-1
- yMedianAddress  in  8  result row, 0..OUT_HEIGHT-1
- dataOut  in  1  median pixel value
- memWrite  out  1  output RAM write strobe, one cycle per byte
- memAddress  out  ADDR_WIDTH  output RAM byte address
- memData  out  8  packed byte; pixel k is in bit k[2:0]
- pixelCount  out  16  pixels accepted in the current frame
- busy  out  1  high in COLLECT
- frameDone  out  1  level; high in DONE
- seqError  out  1  sticky error flag; cleared only by frameStart or reset

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - memWrite, memAddress, memData, pixelCount, busy, frameDone and seqError all 0.
  - Pack register and expected index cleared.
- States: IDLE, COLLECT, DONE.
  - IDLE: frameStart -> COLLECT.
  - COLLECT: last pixel accepted -> DONE.
  - DONE: frameStart -> COLLECT.
  - frameStart in any state clears pixelCount, expected index, pack register and seqError, and enters COLLECT.
- Pixel index: idx = yMedianAddress*OUT_WIDTH + xMedianAddress, computed in 16 bits.
- Accept condition: writeEnable && state==COLLECT && !frameStart && coordinates in range && idx == expected index.
  - On accept: pack[idx[2:0]] <= dataOut, expected and pixelCount increment.
- Rejects:
  - writeEnable in IDLE or DONE: ignored silently.
  - writeEnable in COLLECT with an out-of-range coordinate or idx != expected: pixel dropped, seqError <= 1, expected not advanced.
- Byte flush (registered; memWrite is high in the cycle after the accepting edge):
  - Triggered when the accepted pixel has idx[2:0]==7, or is the last pixel (idx == OUT_WIDTH*OUT_HEIGHT-1).
  - Flush drives memAddress = idx>>3 and memData = the completed byte, with unfilled upper bits forced to 0.
  - Pack register clears for the next byte in the same edge.
  - memWrite is a single-cycle pulse; memAddress and memData hold their values until the next flush.
- Last pixel: flush as above, state -> DONE and frameDone=1 at the same edge that raises memWrite.
- Defaults: last byte address 5295; the final byte carries 4 pixels in bits 3:0, bits 7:4 are 0.
- Simultaneous frameStart and writeEnable: frameStart wins, pixel dropped, no seqError.
- frameStart mid-frame (abort):
  - Partial byte discarded, no flush write.
  - RAM contents from the aborted frame are not cleared.
- Back-to-back writeEnable every cycle is supported; there is no backpressure, and the block always accepts.
- Reset mid-frame: immediate return to IDLE; any pending memWrite is cancelled.

Test Plan:
- Ordered frame at OUT_WIDTH=4, OUT_HEIGHT=3: 12 raster pixels, value = idx[0] -> memWrite at addr0 data 0xAA, then addr1 data 0x0A; frameDone=1, pixelCount=12, seqError=0.
- Default params, full 238x178 raster of all-1 pixels -> 5296 writes; last at addr 5295 with data 0x0F; frameDone rises on the same edge as that write.
- Skipped pixel (x=2 sent after x=0, 4x3 config) -> seqError=1, pixelCount stays 1; resending x=1 then x=2 resumes normal packing.
- Abort: 5 pixels accepted, then frameStart -> no memWrite, pixelCount=0, busy=1; a subsequent full frame produces correct bytes starting at addr0.
- writeEnable in IDLE and in DONE -> no memWrite, no pixelCount change, seqError=0.
- Async reset asserted low mid-frame, between clock edges -> all outputs 0 immediately; state IDLE; no write after release until frameStart.

Source files
------------

// File: rtl/median_result_writer.sv
// median_result_writer: sink for the median filter result stream.
// Checks that result pixels arrive in raster order, packs the 1-bit pixels
// LSB-first into bytes and writes each byte to the output frame RAM.
// frameDone goes high when the frame completes so readout can start.

module median_result_writer #(
  parameter int OUT_WIDTH  = 238,
  parameter int OUT_HEIGHT = 178,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameStart,
  input  logic                  writeEnable,
  input  logic [7:0]            xMedianAddress,
  input  logic [7:0]            yMedianAddress,
  input  logic                  dataOut,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [7:0]            memData,
  output logic [15:0]           pixelCount,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  seqError
);

  localparam logic [15:0] WIDTH16  = 16'(OUT_WIDTH);
  localparam logic [15:0] HEIGHT16 = 16'(OUT_HEIGHT);
  localparam logic [15:0] LAST_IDX = 16'(OUT_WIDTH * OUT_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } stateT;

  stateT       state;
  logic [15:0] expectedIdx;
  logic [7:0]  pack;

  logic [15:0] pixelIdx;
  logic        inRange;
  logic        collecting;
  logic        accept;
  logic        reject;
  logic        isLast;
  logic        endOfByte;
  logic [7:0]  filledByte;
  logic [7:0]  keepMask;

  // Decode the incoming result: raster index, accept/reject, and the byte
  // as it would look with this pixel merged in. keepMask zeroes the bit
  // positions above the current pixel so a short final byte is clean.
  always_comb begin
    pixelIdx   = {8'd0, yMedianAddress} * WIDTH16 + {8'd0, xMedianAddress};
    inRange    = ({8'd0, xMedianAddress} < WIDTH16) &&
                 ({8'd0, yMedianAddress} < HEIGHT16);
    collecting = writeEnable && (state == COLLECT) && !frameStart;
    accept     = collecting && inRange && (pixelIdx == expectedIdx);
    reject     = collecting && !accept;
    isLast     = (pixelIdx == LAST_IDX);
    endOfByte  = (pixelIdx[2:0] == 3'd7);
    filledByte = pack;
    filledByte[pixelIdx[2:0]] = dataOut;
    keepMask   = 8'hFF >> (3'd7 - pixelIdx[2:0]);
  end

  // Frame FSM with pixel packing and registered RAM write port. frameStart
  // has priority over everything else and also serves as the abort path,
  // so a partially packed byte is simply discarded without a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      expectedIdx <= '0;
      pack        <= '0;
      memWrite    <= 1'b0;
      memAddress  <= '0;
      memData     <= '0;
      pixelCount  <= '0;
      busy        <= 1'b0;
      frameDone   <= 1'b0;
      seqError    <= 1'b0;
    end else begin
      memWrite <= 1'b0;
      if (frameStart) begin
        state       <= COLLECT;
        expectedIdx <= '0;
        pack        <= '0;
        pixelCount  <= '0;
        busy        <= 1'b1;
        frameDone   <= 1'b0;
        seqError    <= 1'b0;
      end else if (accept) begin
        expectedIdx <= expectedIdx + 16'd1;
        pixelCount  <= pixelCount + 16'd1;
        if (endOfByte || isLast) begin
          memWrite   <= 1'b1;
          memAddress <= ADDR_WIDTH'(pixelIdx >> 3);
          memData    <= filledByte & keepMask;
          pack       <= '0;
        end else begin
          pack <= filledByte;
        end
        if (isLast) begin
          state     <= DONE;
          busy      <= 1'b0;
          frameDone <= 1'b1;
        end
      end else if (reject) begin
        seqError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_median_result_writer.sv
// tb_median_result_writer: randomized bench for median_result_writer.
// A small 4x3 instance exercises ordering, abort, reset and reject cases
// against a pixel-array model; a default-size instance runs a full frame.

module tb_median_result_writer;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int SA = 4;
  localparam int BW = 238;
  localparam int BH = 178;
  localparam int BA = 13;
  localparam int BTOTAL = BW * BH;
  localparam int BLASTADDR = (BTOTAL + 7) / 8 - 1;
  localparam int BREM = BTOTAL % 8;

  logic clk = 1'b0;
  logic reset;

  logic          sFrameStart, sWriteEnable, sData;
  logic [7:0]    sX, sY;
  logic          sMemWrite;
  logic [SA-1:0] sMemAddress;
  logic [7:0]    sMemData;
  logic [15:0]   sPixelCount;
  logic          sBusy, sFrameDone, sSeqError;

  logic          bFrameStart, bWriteEnable, bData;
  logic [7:0]    bX, bY;
  logic          bMemWrite;
  logic [BA-1:0] bMemAddress;
  logic [7:0]    bMemData;
  logic [15:0]   bPixelCount;
  logic          bBusy, bFrameDone, bSeqError;

  int total = 0;
  int bad = 0;

  // Reference model state for the small instance
  bit            mPix[SW*SH];
  int            mCount;
  bit            mCollecting;
  bit            mFinished;
  bit            mErr;
  logic [SA+7:0] expQ[$];
  int            sWrites = 0;
  int            bWrites = 0;

  always #5 clk = ~clk;

  median_result_writer #(.OUT_WIDTH(SW), .OUT_HEIGHT(SH), .ADDR_WIDTH(SA)) dutSmall (
    .clk(clk), .reset(reset), .frameStart(sFrameStart), .writeEnable(sWriteEnable),
    .xMedianAddress(sX), .yMedianAddress(sY), .dataOut(sData),
    .memWrite(sMemWrite), .memAddress(sMemAddress), .memData(sMemData),
    .pixelCount(sPixelCount), .busy(sBusy), .frameDone(sFrameDone), .seqError(sSeqError)
  );

  median_result_writer #(.OUT_WIDTH(BW), .OUT_HEIGHT(BH), .ADDR_WIDTH(BA)) dutBig (
    .clk(clk), .reset(reset), .frameStart(bFrameStart), .writeEnable(bWriteEnable),
    .xMedianAddress(bX), .yMedianAddress(bY), .dataOut(bData),
    .memWrite(bMemWrite), .memAddress(bMemAddress), .memData(bMemData),
    .pixelCount(bPixelCount), .busy(bBusy), .frameDone(bFrameDone), .seqError(bSeqError)
  );

  // Scoreboard for the small instance: every RAM write must match the next
  // byte the model predicted, in order.
  always @(negedge clk) begin : smallMonitor
    logic [SA+7:0] e;
    if (reset === 1'b1 && sMemWrite === 1'b1) begin
      sWrites++;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpectedWrite: got addr=%0d data=%02h required no write", sMemAddress, sMemData);
      end else begin
        e = expQ.pop_front();
        if ({sMemAddress, sMemData} !== e) begin
          bad++;
          $display("[TB] FAIL writeContent: got addr=%0d data=%02h required addr=%0d data=%02h",
                   sMemAddress, sMemData, e[SA+7:8], e[7:0]);
        end
      end
    end
  end

  // Full-size frame of all-ones: each write must be the next sequential byte
  // and frameDone must be high exactly with the final write.
  always @(negedge clk) begin : bigMonitor
    logic [7:0] expData;
    if (reset === 1'b1 && bMemWrite === 1'b1) begin
      expData = (bWrites == BLASTADDR && BREM != 0) ? 8'((1 << BREM) - 1) : 8'hFF;
      total++;
      if (bMemAddress !== BA'(bWrites) || bMemData !== expData) begin
        bad++;
        $display("[TB] FAIL bigWrite: got addr=%0d data=%02h required addr=%0d data=%02h",
                 bMemAddress, bMemData, bWrites, expData);
      end
      total++;
      if (bFrameDone !== (bWrites == BLASTADDR)) begin
        bad++;
        $display("[TB] FAIL bigFrameDoneEdge: got %b at addr=%0d required %b", bFrameDone, bWrites, (bWrites == BLASTADDR));
      end
      bWrites++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic startFrame(input bit withPixel, input int x, input int y, input logic d);
    sFrameStart  = 1'b1;
    sWriteEnable = withPixel;
    sX = 8'(x);
    sY = 8'(y);
    sData = d;
    mCollecting = 1'b1;
    mFinished = 1'b0;
    mCount = 0;
    mErr = 1'b0;
    foreach (mPix[i]) mPix[i] = 1'b0;
    tick();
    sFrameStart  = 1'b0;
    sWriteEnable = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input logic d);
    int idx;
    logic [7:0] b;
    idx = y * SW + x;
    if (mCollecting) begin
      if (x < SW && y < SH && idx == mCount) begin
        mPix[idx] = d;
        mCount++;
        if (idx % 8 == 7 || idx == SW * SH - 1) begin
          b = 8'h00;
          for (int k = idx - idx % 8; k <= idx; k++) b[k % 8] = mPix[k];
          expQ.push_back({SA'(idx / 8), b});
        end
        if (idx == SW * SH - 1) begin
          mCollecting = 1'b0;
          mFinished = 1'b1;
        end
      end else begin
        mErr = 1'b1;
      end
    end
    sWriteEnable = 1'b1;
    sX = 8'(x);
    sY = 8'(y);
    sData = d;
    tick();
    sWriteEnable = 1'b0;
  endtask

  task automatic test_reset();
    logic [SA+27:0] sAll;
    logic [BA+27:0] bAll;
    reset = 1'b0;
    sFrameStart = 0; sWriteEnable = 0; sX = 0; sY = 0; sData = 0;
    bFrameStart = 0; bWriteEnable = 0; bX = 0; bY = 0; bData = 0;
    mCollecting = 0; mFinished = 0; mCount = 0; mErr = 0;
    #12;
    sAll = {sMemWrite, sMemAddress, sMemData, sPixelCount, sBusy, sFrameDone, sSeqError};
    bAll = {bMemWrite, bMemAddress, bMemData, bPixelCount, bBusy, bFrameDone, bSeqError};
    total++;
    if (sAll !== '0) begin bad++; $display("[TB] FAIL resetSmall: got %h required 0", sAll); end
    total++;
    if (bAll !== '0) begin bad++; $display("[TB] FAIL resetBig: got %h required 0", bAll); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    int w0;
    w0 = sWrites;
    for (int i = 0; i < 9; i++) applyStimulus(i % SW, (i / SW) % SH, 1'b1);
    settle();
    total++;
    if (sWrites != w0 || sPixelCount !== 16'd0 || sSeqError !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idleIgnore: got writes=%0d count=%0d err=%b required writes=%0d count=0 err=0",
               sWrites, sPixelCount, sSeqError, w0);
    end
  endtask

  task automatic test_ordered_frame();
    int w0;
    w0 = sWrites;
    startFrame(0, 0, 0, 1'b0);
    total++;
    if (sBusy !== 1'b1) begin bad++; $display("[TB] FAIL orderedBusy: got %b required 1", sBusy); end
    for (int i = 0; i < SW * SH; i++) applyStimulus(i % SW, i / SW, 1'(i % 2));
    settle();
    total++;
    if (expQ.size() != 0 || sWrites - w0 != (SW * SH + 7) / 8) begin
      bad++;
      $display("[TB] FAIL orderedWrites: got writes=%0d pending=%0d required writes=%0d pending=0",
               sWrites - w0, expQ.size(), (SW * SH + 7) / 8);
    end
    total++;
    if (sPixelCount !== 16'(mCount) || sFrameDone !== mFinished || sSeqError !== mErr || sBusy !== mCollecting) begin
      bad++;
      $display("[TB] FAIL orderedStatus: got count=%0d done=%b err=%b busy=%b required count=%0d done=%b err=%b busy=%b",
               sPixelCount, sFrameDone, sSeqError, sBusy, mCount, mFinished, mErr, mCollecting);
    end
  endtask

  task automatic test_done_ignore();
    int w0;
    w0 = sWrites;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(1, 0, 1'b0);
    applyStimulus(3, 2, 1'b1);
    settle();
    total++;
    if (sWrites != w0 || sPixelCount !== 16'(SW * SH) || sSeqError !== 1'b0 || sFrameDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL doneIgnore: got writes=%0d count=%0d err=%b done=%b required writes=%0d count=%0d err=0 done=1",
               sWrites, sPixelCount, sSeqError, sFrameDone, w0, SW * SH);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      startFrame(0, 0, 0, 1'b0);
      for (int i = 0; i < SW * SH; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
      end
      settle();
      total++;
      if (expQ.size() != 0 || sPixelCount !== 16'(mCount) || sFrameDone !== 1'b1 || sSeqError !== 1'b0) begin
        bad++;
        $display("[TB] FAIL randomFrame%0d: got pending=%0d count=%0d done=%b err=%b required pending=0 count=%0d done=1 err=0",
                 f, expQ.size(), sPixelCount, sFrameDone, sSeqError, mCount);
      end
    end
  endtask

  task automatic test_skip();
    startFrame(0, 0, 0, 1'b0);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(2, 0, 1'b1);
    total++;
    if (sSeqError !== 1'b1 || sPixelCount !== 16'd1) begin
      bad++;
      $display("[TB] FAIL skipDetect: got err=%b count=%0d required err=1 count=1", sSeqError, sPixelCount);
    end
    for (int i = 1; i < SW * SH; i++) applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
    settle();
    total++;
    if (expQ.size() != 0 || sPixelCount !== 16'(mCount) || sSeqError !== mErr || sFrameDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL skipResume: got pending=%0d count=%0d err=%b done=%b required pending=0 count=%0d err=%b done=1",
               expQ.size(), sPixelCount, sSeqError, sFrameDone, mCount, mErr);
    end
  endtask

  task automatic test_out_of_range();
    startFrame(0, 0, 0, 1'b0);
    total++;
    if (sSeqError !== 1'b0) begin bad++; $display("[TB] FAIL frameStartClearsErr: got %b required 0", sSeqError); end
    for (int i = 0; i < 4; i++) applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
    applyStimulus(SW, 0, 1'b1);
    applyStimulus(0, SH, 1'b1);
    total++;
    if (sSeqError !== 1'b1 || sPixelCount !== 16'd4) begin
      bad++;
      $display("[TB] FAIL outOfRange: got err=%b count=%0d required err=1 count=4", sSeqError, sPixelCount);
    end
    for (int i = 4; i < SW * SH; i++) applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
    settle();
    total++;
    if (expQ.size() != 0 || sPixelCount !== 16'(mCount)) begin
      bad++;
      $display("[TB] FAIL outOfRangeResume: got pending=%0d count=%0d required pending=0 count=%0d",
               expQ.size(), sPixelCount, mCount);
    end
  endtask

  task automatic test_simultaneous_and_abort();
    int w0;
    startFrame(1, 0, 0, 1'b1);
    total++;
    if (sPixelCount !== 16'd0 || sSeqError !== 1'b0 || sBusy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simultaneous: got count=%0d err=%b busy=%b required count=0 err=0 busy=1",
               sPixelCount, sSeqError, sBusy);
    end
    for (int i = 0; i < 5; i++) applyStimulus(i % SW, i / SW, 1'b1);
    w0 = sWrites;
    startFrame(0, 0, 0, 1'b0);
    settle();
    total++;
    if (sWrites != w0 || sPixelCount !== 16'd0 || sBusy !== 1'b1 || sFrameDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort: got writes=%0d count=%0d busy=%b done=%b required writes=%0d count=0 busy=1 done=0",
               sWrites, sPixelCount, sBusy, sFrameDone, w0);
    end
    for (int i = 0; i < SW * SH; i++) applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
    settle();
    total++;
    if (expQ.size() != 0 || sPixelCount !== 16'(mCount) || sFrameDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL afterAbort: got pending=%0d count=%0d done=%b required pending=0 count=%0d done=1",
               expQ.size(), sPixelCount, sFrameDone, mCount);
    end
  endtask

  task automatic test_async_reset();
    logic [SA+27:0] sAll;
    int w0;
    startFrame(0, 0, 0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(i % SW, i / SW, 1'($urandom_range(0, 1)));
    applyStimulus(3, 1, 1'b1);
    total++;
    if (sMemWrite !== 1'b1) begin bad++; $display("[TB] FAIL byteFlushPulse: got %b required 1", sMemWrite); end
    #2;
    reset = 1'b0;
    mCollecting = 0; mFinished = 0; mCount = 0; mErr = 0;
    expQ.delete();
    #1;
    sAll = {sMemWrite, sMemAddress, sMemData, sPixelCount, sBusy, sFrameDone, sSeqError};
    total++;
    if (sAll !== '0) begin bad++; $display("[TB] FAIL asyncReset: got %h required 0", sAll); end
    @(negedge clk);
    reset = 1'b1;
    w0 = sWrites;
    for (int i = 0; i < 8; i++) applyStimulus(i % SW, i / SW, 1'b1);
    settle();
    total++;
    if (sWrites != w0 || sPixelCount !== 16'd0 || sBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL afterReset: got writes=%0d count=%0d busy=%b required writes=%0d count=0 busy=0",
               sWrites, sPixelCount, sBusy, w0);
    end
    startFrame(0, 0, 0, 1'b0);
    total++;
    if (sBusy !== 1'b1) begin bad++; $display("[TB] FAIL rearmAfterReset: got busy=%b required 1", sBusy); end
  endtask

  task automatic test_back_to_back();
    bFrameStart = 1'b1;
    tick();
    bFrameStart = 1'b0;
    for (int i = 0; i < BTOTAL; i++) begin
      bWriteEnable = 1'b1;
      bX = 8'(i % BW);
      bY = 8'(i / BW);
      bData = 1'b1;
      tick();
    end
    bWriteEnable = 1'b0;
    settle();
    total++;
    if (bWrites != BLASTADDR + 1) begin
      bad++;
      $display("[TB] FAIL bigWriteCount: got %0d required %0d", bWrites, BLASTADDR + 1);
    end
    total++;
    if (bPixelCount !== 16'(BTOTAL) || bFrameDone !== 1'b1 || bSeqError !== 1'b0 || bBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bigStatus: got count=%0d done=%b err=%b busy=%b required count=%0d done=1 err=0 busy=0",
               bPixelCount, bFrameDone, bSeqError, bBusy, BTOTAL);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_idle_ignore();
    test_ordered_frame();
    test_done_ignore();
    test_random_frames();
    test_skip();
    test_out_of_range();
    test_simultaneous_and_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
